cbfp_scale_restore: RTL and testbench

- Back end of the CBFP path: consumes the 16-lane normalized stream that cbfp_module produces, plus the per-sample accumulated shift indices (index1 + index2).
- Restores absolute scale per sample relative to REF_SUM: right-shift with truncation or left-shift with saturation.
- Emits frame-aligned 16-lane output with start/end-of-frame markers and a per-frame saturation count.
- Sits between the last CBFP stage and the FFT output reorder/capture logic.

---
 rtl/cbfp_scale_restore.sv | 200 ++++++++++++++++++++
 tb/tb_cbfp_scale_restore.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_scale_restore.sv
// CBFP back end: restores absolute scale per sample from the accumulated block
// exponents, frames the 16-lane stream and counts saturated samples per frame.
module cbfp_scale_restore #(
    parameter int unsigned IN_W      = 13,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned SHIFT_W   = 5,
    parameter int unsigned REF_SUM   = 23,
    parameter int unsigned LANES     = 16,
    parameter int unsigned TOTAL_SAM = 512,
    parameter int unsigned MAX_SH    = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic signed [IN_W-1:0]    data_re_in   [0:LANES-1],
    input  logic signed [IN_W-1:0]    data_im_in   [0:LANES-1],
    input  logic        [SHIFT_W-1:0] index1_re_in [0:LANES-1],
    input  logic        [SHIFT_W-1:0] index1_im_in [0:LANES-1],
    input  logic        [SHIFT_W-1:0] index2_re_in [0:LANES-1],
    input  logic        [SHIFT_W-1:0] index2_im_in [0:LANES-1],
    output logic signed [OUT_W-1:0]   data_re_out  [0:LANES-1],
    output logic signed [OUT_W-1:0]   data_im_out  [0:LANES-1],
    output logic                      valid_out,
    output logic                      sof_out,
    output logic                      eof_out,
    output logic        [9:0]         sat_cnt,
    output logic                      sat_cnt_valid
);

    localparam int unsigned CYCLES = TOTAL_SAM / LANES;
    localparam int unsigned CNT_W  = $clog2(CYCLES);
    localparam int unsigned SUM_W  = SHIFT_W + 1;
    localparam int unsigned D_W    = SHIFT_W + 2;
    localparam int unsigned SH_W   = $clog2(MAX_SH + 1);
    localparam int unsigned WIDE_W = OUT_W + MAX_SH;
    localparam int unsigned BS_W   = $clog2(2 * LANES + 1);
    localparam int unsigned SATC_W = 10;

    localparam logic signed [WIDE_W-1:0] MAX_WIDE = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] MIN_WIDE = {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [D_W-1:0]    MAX_SH_D = D_W'(MAX_SH);

    // Signed distance of the exponent sum from unity scale.
    function automatic logic signed [D_W-1:0] idx_diff(input logic [SHIFT_W-1:0] a,
                                                       input logic [SHIFT_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        return $signed(D_W'(sum) - D_W'(REF_SUM));
    endfunction

    // Returns {saturated, result}: floor right shift for d>0, saturating left shift for d<0.
    function automatic logic [OUT_W:0] restore(input logic signed [OUT_W-1:0] x,
                                               input logic signed [D_W-1:0]   d);
        logic [SH_W-1:0]          sh;
        logic signed [D_W-1:0]    nd;
        logic signed [WIDE_W-1:0] wide;
        logic signed [OUT_W-1:0]  y;
        logic                     sat;
        sh   = '0;
        nd   = -d;
        wide = '0;
        y    = x;
        sat  = 1'b0;
        if (d > 0) begin
            sh = (d > MAX_SH_D) ? SH_W'(MAX_SH) : SH_W'(d);
            y  = x >>> sh;
        end else if (d < 0) begin
            sh   = (nd > MAX_SH_D) ? SH_W'(MAX_SH) : SH_W'(nd);
            wide = WIDE_W'(x) <<< sh;
            if (wide > MAX_WIDE) begin
                y   = MAX_WIDE[OUT_W-1:0];
                sat = 1'b1;
            end else if (wide < MIN_WIDE) begin
                y   = MIN_WIDE[OUT_W-1:0];
                sat = 1'b1;
            end else begin
                y = OUT_W'(wide);
            end
        end
        return {sat, y};
    endfunction

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_sof_q, s1_sof_d;
    logic                     s1_eof_q, s1_eof_d;
    logic signed [OUT_W-1:0]  s1_re_q [LANES], s1_re_d [LANES];
    logic signed [OUT_W-1:0]  s1_im_q [LANES], s1_im_d [LANES];
    logic signed [D_W-1:0]    d_re_q  [LANES], d_re_d  [LANES];
    logic signed [D_W-1:0]    d_im_q  [LANES], d_im_d  [LANES];

    logic signed [OUT_W-1:0]  out_re_q [LANES], out_re_d [LANES];
    logic signed [OUT_W-1:0]  out_im_q [LANES], out_im_d [LANES];
    logic                     valid_out_q, valid_out_d;
    logic                     sof_out_q, sof_out_d;
    logic                     eof_out_q, eof_out_d;
    logic [SATC_W-1:0]        acc_q, acc_d;
    logic [SATC_W-1:0]        sat_cnt_q, sat_cnt_d;
    logic                     sat_cnt_valid_q, sat_cnt_valid_d;
    logic [BS_W-1:0]          beat_sat_c;

    // Stage 1: beat tagging, exponent difference, sign extension.
    always_comb begin
        cnt_d      = cnt_q;
        s1_valid_d = valid_in;
        s1_sof_d   = valid_in && (cnt_q == '0);
        s1_eof_d   = valid_in && (cnt_q == CNT_W'(CYCLES - 1));
        if (valid_in) begin
            cnt_d = (cnt_q == CNT_W'(CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
        for (int l = 0; l < LANES; l++) begin
            s1_re_d[l] = OUT_W'(data_re_in[l]);
            s1_im_d[l] = OUT_W'(data_im_in[l]);
            d_re_d[l]  = idx_diff(index1_re_in[l], index2_re_in[l]);
            d_im_d[l]  = idx_diff(index1_im_in[l], index2_im_in[l]);
        end
    end

    // Stage 2: shift/saturate, frame markers and saturation accounting.
    always_comb begin
        logic [OUT_W:0] r_re;
        logic [OUT_W:0] r_im;
        r_re            = '0;
        r_im            = '0;
        beat_sat_c      = '0;
        out_re_d        = out_re_q;
        out_im_d        = out_im_q;
        valid_out_d     = s1_valid_q;
        sof_out_d       = s1_valid_q && s1_sof_q;
        eof_out_d       = s1_valid_q && s1_eof_q;
        acc_d           = acc_q;
        sat_cnt_d       = sat_cnt_q;
        sat_cnt_valid_d = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            r_re       = restore(s1_re_q[l], d_re_q[l]);
            r_im       = restore(s1_im_q[l], d_im_q[l]);
            beat_sat_c = beat_sat_c + BS_W'(r_re[OUT_W]) + BS_W'(r_im[OUT_W]);
            if (s1_valid_q) begin
                out_re_d[l] = r_re[OUT_W-1:0];
                out_im_d[l] = r_im[OUT_W-1:0];
            end
        end
        if (s1_valid_q) begin
            if (s1_eof_q) begin
                sat_cnt_d       = acc_q + SATC_W'(beat_sat_c);
                sat_cnt_valid_d = 1'b1;
                acc_d           = '0;
            end else begin
                acc_d = acc_q + SATC_W'(beat_sat_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q           <= '0;
            s1_valid_q      <= 1'b0;
            s1_sof_q        <= 1'b0;
            s1_eof_q        <= 1'b0;
            s1_re_q         <= '{default: '0};
            s1_im_q         <= '{default: '0};
            d_re_q          <= '{default: '0};
            d_im_q          <= '{default: '0};
            out_re_q        <= '{default: '0};
            out_im_q        <= '{default: '0};
            valid_out_q     <= 1'b0;
            sof_out_q       <= 1'b0;
            eof_out_q       <= 1'b0;
            acc_q           <= '0;
            sat_cnt_q       <= '0;
            sat_cnt_valid_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            s1_valid_q      <= s1_valid_d;
            s1_sof_q        <= s1_sof_d;
            s1_eof_q        <= s1_eof_d;
            s1_re_q         <= s1_re_d;
            s1_im_q         <= s1_im_d;
            d_re_q          <= d_re_d;
            d_im_q          <= d_im_d;
            out_re_q        <= out_re_d;
            out_im_q        <= out_im_d;
            valid_out_q     <= valid_out_d;
            sof_out_q       <= sof_out_d;
            eof_out_q       <= eof_out_d;
            acc_q           <= acc_d;
            sat_cnt_q       <= sat_cnt_d;
            sat_cnt_valid_q <= sat_cnt_valid_d;
        end
    end

    assign data_re_out   = out_re_q;
    assign data_im_out   = out_im_q;
    assign valid_out     = valid_out_q;
    assign sof_out       = sof_out_q;
    assign eof_out       = eof_out_q;
    assign sat_cnt       = sat_cnt_q;
    assign sat_cnt_valid = sat_cnt_valid_q;

endmodule

// File: tb/tb_cbfp_scale_restore.sv
// Directed bench for cbfp_scale_restore: expected beats are queued at drive
// time from an arithmetic reference model and compared as the DUT emits them.
module tb_cbfp_scale_restore;

    localparam int LANES  = 16;
    localparam int IN_W   = 13;
    localparam int OUT_W  = 16;
    localparam int SW     = 5;
    localparam int CYCLES = 32;

    typedef struct packed {
        logic [LANES-1:0][OUT_W-1:0] re;
        logic [LANES-1:0][OUT_W-1:0] im;
        logic                        sof;
        logic                        eof;
        logic                        satv;
        logic [9:0]                  satc;
        logic [31:0]                 cyc;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     valid_in = 1'b0;
    logic signed [IN_W-1:0]   data_re_in   [0:LANES-1];
    logic signed [IN_W-1:0]   data_im_in   [0:LANES-1];
    logic        [SW-1:0]     index1_re_in [0:LANES-1];
    logic        [SW-1:0]     index1_im_in [0:LANES-1];
    logic        [SW-1:0]     index2_re_in [0:LANES-1];
    logic        [SW-1:0]     index2_im_in [0:LANES-1];
    logic signed [OUT_W-1:0]  data_re_out  [0:LANES-1];
    logic signed [OUT_W-1:0]  data_im_out  [0:LANES-1];
    logic                     valid_out, sof_out, eof_out, sat_cnt_valid;
    logic [9:0]               sat_cnt;

    cbfp_scale_restore dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .data_re_in(data_re_in), .data_im_in(data_im_in),
        .index1_re_in(index1_re_in), .index1_im_in(index1_im_in),
        .index2_re_in(index2_re_in), .index2_im_in(index2_im_in),
        .data_re_out(data_re_out), .data_im_out(data_im_out),
        .valid_out(valid_out), .sof_out(sof_out), .eof_out(eof_out),
        .sat_cnt(sat_cnt), .sat_cnt_valid(sat_cnt_valid)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t mon_e;

    int b_re[LANES], b_im[LANES], i1r[LANES], i2r[LANES], i1i[LANES], i2i[LANES];
    int m_cnt = 0, m_acc = 0, m_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: floor division for right shifts, multiply and clamp for left shifts.
    function automatic int gold(input int x, input int s, output bit sat);
        int d, sh, p, r;
        d   = s - 23;
        sat = 1'b0;
        r   = x;
        if (d > 0) begin
            sh = (d > 15) ? 15 : d;
            p  = 1 << sh;
            r  = x / p;
            if (x < 0 && (x % p) != 0) r = r - 1;
        end else if (d < 0) begin
            sh = (-d > 15) ? 15 : -d;
            r  = x * (1 << sh);
            if (r > 32767) begin r = 32767; sat = 1'b1; end
            else if (r < -32768) begin r = -32768; sat = 1'b1; end
        end
        return r;
    endfunction

    task automatic send();
        exp_t e;
        bit   sat;
        int   v;
        int   nsat = 0;
        e = '0;
        for (int l = 0; l < LANES; l++) begin
            data_re_in[l]   = IN_W'(b_re[l]);
            data_im_in[l]   = IN_W'(b_im[l]);
            index1_re_in[l] = SW'(i1r[l]);
            index2_re_in[l] = SW'(i2r[l]);
            index1_im_in[l] = SW'(i1i[l]);
            index2_im_in[l] = SW'(i2i[l]);
            v = gold(b_re[l], i1r[l] + i2r[l], sat);
            e.re[l] = OUT_W'(v);
            nsat += int'(sat);
            v = gold(b_im[l], i1i[l] + i2i[l], sat);
            e.im[l] = OUT_W'(v);
            nsat += int'(sat);
        end
        e.sof = (m_cnt == 0);
        e.eof = (m_cnt == CYCLES - 1);
        m_cnt = (m_cnt + 1) % CYCLES;
        if (e.eof) begin
            m_last = m_acc + nsat;
            m_acc  = 0;
            e.satv = 1'b1;
        end else begin
            m_acc += nsat;
        end
        e.satc = 10'(m_last);
        e.cyc  = 32'(cyc);
        sb.push_back(e);
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            data_re_in[l]   = IN_W'($urandom);
            data_im_in[l]   = IN_W'($urandom);
            index1_re_in[l] = SW'($urandom);
            index2_re_in[l] = SW'($urandom);
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int re, input int im, input int a, input int b);
        for (int l = 0; l < LANES; l++) begin
            b_re[l] = re; b_im[l] = im;
            i1r[l] = a; i2r[l] = b; i1i[l] = a; i2i[l] = b;
        end
    endtask

    task automatic fill_rand();
        for (int l = 0; l < LANES; l++) begin
            b_re[l] = int'($urandom_range(0, 8191)) - 4096;
            b_im[l] = int'($urandom_range(0, 8191)) - 4096;
            i1r[l] = int'($urandom_range(0, 31)); i2r[l] = int'($urandom_range(0, 31));
            i1i[l] = int'($urandom_range(0, 31)); i2i[l] = int'($urandom_range(0, 31));
        end
    endtask

    // Output monitor: every valid beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out && sb.size() == 0) begin
                chk("unexpected_beat", 32'(valid_out), 32'(0));
            end else if (valid_out) begin
                mon_e = sb.pop_front();
                chk("latency", 32'(cyc) - mon_e.cyc, 32'(2));
                for (int l = 0; l < LANES; l++) begin
                    chk($sformatf("re_lane%0d", l), 32'($unsigned(data_re_out[l])), 32'(mon_e.re[l]));
                    chk($sformatf("im_lane%0d", l), 32'($unsigned(data_im_out[l])), 32'(mon_e.im[l]));
                end
                chk("sof", 32'(sof_out), 32'(mon_e.sof));
                chk("eof", 32'(eof_out), 32'(mon_e.eof));
                chk("sat_cnt_valid", 32'(sat_cnt_valid), 32'(mon_e.satv));
                chk("sat_cnt", 32'(sat_cnt), 32'(mon_e.satc));
            end else begin
                chk("sat_cnt_valid_idle", 32'(sat_cnt_valid), 32'(0));
            end
        end
    end

    initial begin
        int t;
        fill(0, 0, 0, 0);
        idle(3);
        chk("rst_valid_out", 32'(valid_out), 32'(0));
        chk("rst_sof", 32'(sof_out), 32'(0));
        chk("rst_eof", 32'(eof_out), 32'(0));
        chk("rst_sat_cnt", 32'(sat_cnt), 32'(0));
        chk("rst_sat_cnt_valid", 32'(sat_cnt_valid), 32'(0));
        chk("rst_data_re0", 32'($unsigned(data_re_out[0])), 32'(0));
        chk("rst_data_im15", 32'($unsigned(data_im_out[15])), 32'(0));
        rst = 1'b0;
        idle(2);

        // Unity scale, full-range data.
        fill(-4096, 4095, 11, 12);
        repeat (CYCLES) send();
        idle(2);

        // Right shifts: floor behaviour and shift clamped at 15.
        for (int b = 0; b < CYCLES; b++) begin
            if (b % 2 == 0) fill(-5, 7, 13, 13);
            else            fill(-4096, 4095, 23, 20);
            send();
        end
        idle(2);

        // Left shift by 10: im saturates on every lane and beat.
        fill(31, 32, 6, 7);
        repeat (CYCLES) send();
        idle(3);

        // Gapped frame followed back-to-back by another frame.
        for (int b = 0; b < CYCLES; b++) begin
            fill_rand();
            send();
            if (b == 10) idle(3);
        end
        for (int b = 0; b < CYCLES; b++) begin
            fill_rand();
            send();
        end
        idle(2);

        // Reset part-way through a saturating frame.
        fill(31, 32, 6, 7);
        repeat (17) send();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt = 0; m_acc = 0; m_last = 0;
        chk("midrst_valid_out", 32'(valid_out), 32'(0));
        chk("midrst_sat_cnt", 32'(sat_cnt), 32'(0));
        chk("midrst_data_re0", 32'($unsigned(data_re_out[0])), 32'(0));
        fill(-7, 9, 4, 5);
        send();
        chk("midrst_valid_out_next", 32'(valid_out), 32'(0));
        repeat (CYCLES - 1) send();
        idle(2);

        // Per-lane independence: distinct re/im sums per lane, random data.
        repeat (2) begin
            for (int b = 0; b < CYCLES; b++) begin
                fill_rand();
                for (int l = 0; l < LANES; l++) begin
                    i1r[l] = (13 + l) / 2;       i2r[l] = 13 + l - i1r[l];
                    i1i[l] = (28 - l) / 3;       i2i[l] = 28 - l - i1i[l];
                end
                send();
            end
        end

        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 32'(sb.size()), 32'(0));
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
